// File: rtl/player_ctrl_pkg.sv
// rtl/player_ctrl_pkg.sv - shared types, widths and helpers for the player sequencer
package player_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ALIVE,
        INVULN,
        EXPLODE,
        GAME_OVER
    } state_t;

    localparam int LIVES_W     = 3;
    localparam int FRAME_CNT_W = 8;

    function automatic logic rise_edge(input logic cur, input logic prev);
        return cur & ~prev;
    endfunction

endpackage

// File: rtl/player_ctrl_frame_countdown.sv
// rtl/player_ctrl_frame_countdown.sv - loadable per-frame down-counter saturating at zero
module frame_countdown #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         tick,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    // A load wins over a coincident tick so a freshly armed timer starts full.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/player_ctrl.sv
// rtl/player_ctrl.sv - lives, explosion/respawn/invulnerability sequencing, movement gating and fire rate limit
module player_ctrl
    import player_ctrl_pkg::*;
#(
    parameter int INIT_LIVES     = 3,
    parameter int EXPLODE_FRAMES = 30,
    parameter int INVULN_FRAMES  = 60,
    parameter int BLINK_FRAMES   = 4,
    parameter int FIRE_COOLDOWN  = 15,
    parameter int LEFT_LIMIT     = 0,
    parameter int RIGHT_LIMIT    = 607
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               startGame,
    input  logic               hitDetected,
    input  logic               keyRight,
    input  logic               keyLeft,
    input  logic               keyFire,
    input  logic [10:0]        playerX,
    output logic               right,
    output logic               left,
    output logic               plrHit,
    output logic               playerVisible,
    output logic               fireReq,
    output logic [LIVES_W-1:0] lives,
    output logic               exploding,
    output logic               gameOver
);

    state_t               state, state_n;
    logic [LIVES_W-1:0]   lives_n;
    logic                 fire_prev;
    logic                 fire_edge;
    logic                 right_n, left_n, plr_hit_n, vis_n, fire_n;
    logic                 moving_state;

    logic                 timer_load, timer_zero;
    logic [FRAME_CNT_W-1:0] timer_val;
    logic                 blink_load, blink_zero;
    logic                 cool_load, cool_zero;
    logic [FRAME_CNT_W-1:0] cool_val;

    assign fire_edge = rise_edge(keyFire, fire_prev);

    frame_countdown #(.W(FRAME_CNT_W)) u_state_timer (
        .clk      (clk),
        .resetN   (resetN),
        .tick     (startOfFrame),
        .load     (timer_load),
        .load_val (timer_val),
        .zero     (timer_zero)
    );

    frame_countdown #(.W(FRAME_CNT_W)) u_blink_timer (
        .clk      (clk),
        .resetN   (resetN),
        .tick     (startOfFrame),
        .load     (blink_load),
        .load_val (FRAME_CNT_W'(BLINK_FRAMES)),
        .zero     (blink_zero)
    );

    frame_countdown #(.W(FRAME_CNT_W)) u_fire_cooldown (
        .clk      (clk),
        .resetN   (resetN),
        .tick     (startOfFrame),
        .load     (cool_load),
        .load_val (cool_val),
        .zero     (cool_zero)
    );

    always_comb begin
        state_n    = state;
        lives_n    = lives;
        plr_hit_n  = 1'b0;
        fire_n     = 1'b0;
        timer_load = 1'b0;
        timer_val  = '0;
        cool_load  = 1'b0;
        cool_val   = '0;

        case (state)
            IDLE, GAME_OVER: begin
                if (startGame) begin
                    state_n   = ALIVE;
                    lives_n   = LIVES_W'(INIT_LIVES);
                    plr_hit_n = 1'b1;
                    cool_load = 1'b1;
                end
            end
            ALIVE: begin
                if (hitDetected && (lives != '0)) begin
                    state_n    = EXPLODE;
                    lives_n    = lives - 1'b1;
                    timer_load = 1'b1;
                    timer_val  = FRAME_CNT_W'(EXPLODE_FRAMES);
                end
            end
            INVULN: begin
                if (timer_zero) begin
                    state_n = ALIVE;
                end
            end
            EXPLODE: begin
                if (timer_zero) begin
                    if (lives != '0) begin
                        state_n    = INVULN;
                        plr_hit_n  = 1'b1;
                        timer_load = 1'b1;
                        timer_val  = FRAME_CNT_W'(INVULN_FRAMES);
                    end else begin
                        state_n = GAME_OVER;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // A hit taken this cycle suppresses any shot, so only non-exploding successors may fire.
        if (((state == ALIVE) || (state == INVULN)) && (state_n != EXPLODE)
            && fire_edge && cool_zero) begin
            fire_n    = 1'b1;
            cool_load = 1'b1;
            cool_val  = FRAME_CNT_W'(FIRE_COOLDOWN);
        end
    end

    assign moving_state = (state_n == ALIVE) || (state_n == INVULN);
    assign blink_load   = (state_n == INVULN) && ((state != INVULN) || blink_zero);

    always_comb begin
        right_n = moving_state & keyRight & ~keyLeft & (playerX < 11'(RIGHT_LIMIT));
        left_n  = moving_state & keyLeft & ~keyRight & (playerX > 11'(LEFT_LIMIT));
        vis_n   = 1'b0;
        case (state_n)
            ALIVE, EXPLODE: vis_n = 1'b1;
            INVULN: begin
                if (state != INVULN) begin
                    vis_n = 1'b1;
                end else if (blink_zero) begin
                    vis_n = ~playerVisible;
                end else begin
                    vis_n = playerVisible;
                end
            end
            default: vis_n = 1'b0;
        endcase
    end

    // plrHit must come straight from a flop: downstream uses it as an asynchronous reset.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state         <= IDLE;
            lives         <= '0;
            fire_prev     <= 1'b0;
            right         <= 1'b0;
            left          <= 1'b0;
            plrHit        <= 1'b0;
            playerVisible <= 1'b0;
            fireReq       <= 1'b0;
            exploding     <= 1'b0;
            gameOver      <= 1'b0;
        end else begin
            state         <= state_n;
            lives         <= lives_n;
            fire_prev     <= keyFire;
            right         <= right_n;
            left          <= left_n;
            plrHit        <= plr_hit_n;
            playerVisible <= vis_n;
            fireReq       <= fire_n;
            exploding     <= (state_n == EXPLODE);
            gameOver      <= (state_n == GAME_OVER);
        end
    end

endmodule

// File: tb/tb_player_ctrl.sv
// tb/tb_player_ctrl.sv - directed self-checking bench for player_ctrl
module tb_player_ctrl;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame;
    logic        startGame;
    logic        hitDetected;
    logic        keyRight, keyLeft, keyFire;
    logic [10:0] playerX;
    logic        right, left, plrHit, playerVisible, fireReq, exploding, gameOver;
    logic [2:0]  lives;

    int checks = 0;
    int errors = 0;
    int plr_pulses = 0;

    always #5 clk = ~clk;

    player_ctrl dut (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (startOfFrame),
        .startGame     (startGame),
        .hitDetected   (hitDetected),
        .keyRight      (keyRight),
        .keyLeft       (keyLeft),
        .keyFire       (keyFire),
        .playerX       (playerX),
        .right         (right),
        .left          (left),
        .plrHit        (plrHit),
        .playerVisible (playerVisible),
        .fireReq       (fireReq),
        .lives         (lives),
        .exploding     (exploding),
        .gameOver      (gameOver)
    );

    always @(negedge clk) if (plrHit === 1'b1) plr_pulses++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            startOfFrame = 1'b1;
            @(negedge clk);
            startOfFrame = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic pulse_hit();
        hitDetected = 1'b1;
        cyc(1);
        hitDetected = 1'b0;
    endtask

    initial begin
        resetN = 1'b0; startOfFrame = 1'b0; startGame = 1'b0; hitDetected = 1'b0;
        keyRight = 1'b0; keyLeft = 1'b0; keyFire = 1'b0; playerX = 11'd300;
        cyc(2);
        chk("rst_lives", 32'(lives), 32'd0);
        chk("rst_plrhit", 32'(plrHit), 32'd0);
        chk("rst_visible", 32'(playerVisible), 32'd0);
        chk("rst_gameover", 32'(gameOver), 32'd0);
        chk("rst_outs", {26'd0, right, left, fireReq, exploding, plrHit, playerVisible}, 32'd0);
        resetN = 1'b1;
        cyc(2);

        startGame = 1'b1;
        cyc(1);
        startGame = 1'b0;
        chk("start_lives", 32'(lives), 32'd3);
        chk("start_plrhit", 32'(plrHit), 32'd1);
        chk("start_visible", 32'(playerVisible), 32'd1);
        cyc(1);
        chk("start_plrhit_one_cycle", 32'(plrHit), 32'd0);

        playerX = 11'd607; keyRight = 1'b1; cyc(1);
        chk("right_at_limit", 32'(right), 32'd0);
        playerX = 11'd606; cyc(1);
        chk("right_below_limit", 32'(right), 32'd1);
        playerX = 11'd300; keyLeft = 1'b1; cyc(1);
        chk("both_keys", {30'd0, right, left}, 32'd0);
        keyRight = 1'b0; cyc(1);
        chk("left_mid", 32'(left), 32'd1);
        playerX = 11'd0; cyc(1);
        chk("left_at_limit", 32'(left), 32'd0);
        keyLeft = 1'b0; playerX = 11'd300;

        keyFire = 1'b1; cyc(1);
        chk("fire_f0", 32'(fireReq), 32'd1);
        keyFire = 1'b0; cyc(1);
        chk("fire_one_cycle", 32'(fireReq), 32'd0);
        frames(5);
        keyFire = 1'b1; cyc(1);
        chk("fire_f5_dropped", 32'(fireReq), 32'd0);
        keyFire = 1'b0; cyc(1);
        frames(11);
        keyFire = 1'b1; cyc(1);
        chk("fire_f16", 32'(fireReq), 32'd1);
        keyFire = 1'b0; cyc(1);

        pulse_hit();
        chk("hit1_lives", 32'(lives), 32'd2);
        chk("hit1_exploding", 32'(exploding), 32'd1);
        chk("hit1_visible", 32'(playerVisible), 32'd1);
        plr_pulses = 0;
        frames(29);
        chk("explode29_exploding", 32'(exploding), 32'd1);
        chk("explode29_no_plrhit", 32'(plr_pulses), 32'd0);
        frames(1);
        chk("respawn_plrhit_once", 32'(plr_pulses), 32'd1);
        chk("invuln_not_exploding", 32'(exploding), 32'd0);
        chk("invuln_visible_start", 32'(playerVisible), 32'd1);
        frames(3);
        chk("blink_3", 32'(playerVisible), 32'd1);
        frames(1);
        chk("blink_4", 32'(playerVisible), 32'd0);
        frames(4);
        chk("blink_8", 32'(playerVisible), 32'd1);

        hitDetected = 1'b1;
        frames(51);
        chk("invuln_hit_ignored_lives", 32'(lives), 32'd2);
        chk("invuln_hit_ignored_state", 32'(exploding), 32'd0);
        frames(1);
        chk("post_invuln_exploding", 32'(exploding), 32'd1);
        chk("post_invuln_lives", 32'(lives), 32'd1);
        hitDetected = 1'b0;

        frames(30);
        frames(60);
        chk("alive_again_exploding", 32'(exploding), 32'd0);
        chk("alive_again_visible", 32'(playerVisible), 32'd1);
        hitDetected = 1'b1; keyFire = 1'b1;
        cyc(1);
        hitDetected = 1'b0;
        chk("hit_beats_fire", 32'(fireReq), 32'd0);
        chk("hit3_lives", 32'(lives), 32'd0);
        keyFire = 1'b0;
        plr_pulses = 0;
        frames(30);
        chk("gameover_flag", 32'(gameOver), 32'd1);
        chk("gameover_lives", 32'(lives), 32'd0);
        chk("gameover_no_plrhit", 32'(plr_pulses), 32'd0);
        chk("gameover_exploding", 32'(exploding), 32'd0);

        startGame = 1'b1; cyc(1); startGame = 1'b0;
        chk("restart_gameover_clr", 32'(gameOver), 32'd0);
        chk("restart_lives", 32'(lives), 32'd3);
        chk("restart_plrhit", 32'(plrHit), 32'd1);
        cyc(1);
        startGame = 1'b1; cyc(1); startGame = 1'b0;
        chk("start_ignored_in_alive", 32'(plrHit), 32'd0);

        pulse_hit();
        frames(5);
        chk("pre_reset_exploding", 32'(exploding), 32'd1);
        #2 resetN = 1'b0;
        #1;
        chk("async_rst_exploding", 32'(exploding), 32'd0);
        chk("async_rst_lives", 32'(lives), 32'd0);
        chk("async_rst_visible", 32'(playerVisible), 32'd0);
        chk("async_rst_plrhit", 32'(plrHit), 32'd0);
        cyc(2);
        resetN = 1'b1;
        plr_pulses = 0;
        cyc(3);
        chk("no_plrhit_after_reset", 32'(plr_pulses), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/player_ctrl.md
Name: player_ctrl

Overview:
- Sequences the player-ship movement block: gates left/right commands and fires its respawn pulse.
- Tracks lives, runs the explosion/respawn/invulnerability sequence, blinks the ship while invulnerable, and rate-limits fire requests.
- Sits between the keypad/collision logic and the player movement and drawing blocks; all timing is counted in frames via startOfFrame.

Parameters:
- INIT_LIVES, 3, lives loaded on game start (1..7).
- EXPLODE_FRAMES, 30, frames spent in EXPLODE.
- INVULN_FRAMES, 60, frames of post-respawn invulnerability.
- BLINK_FRAMES, 4, frames per visible/invisible half-period while invulnerable.
- FIRE_COOLDOWN, 15, frames between accepted shots.
- LEFT_LIMIT, 0, playerX at or below which left is blocked.
- RIGHT_LIMIT, 607, playerX at or above which right is blocked.

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous active-low reset.
- startOfFrame  in  1  one-cycle pulse per frame.
- startGame  in  1  level; starts a game from IDLE or GAME_OVER.
- hitDetected  in  1  level; player collided with an enemy shot or enemy.
- keyRight, keyLeft, keyFire  in  1 each  raw key levels.
- playerX  in  11  current player top-left X.
- right, left  out  1 each  movement commands to the movement block.
- plrHit  out  1  registered one-cycle respawn pulse (returns ship to initial position).
- playerVisible  out  1  drawing enable.
- fireReq  out  1  one-cycle shot request.
- lives  out  3  remaining lives.
- exploding  out  1  high in EXPLODE (selects explosion sprite).
- gameOver  out  1  high in GAME_OVER.

Behaviour:
- One clock; reset is asynchronous and active-low, ports clk and resetN. All outputs registered.
- Reset values: state=IDLE, lives=0, right/left/plrHit/fireReq/exploding/gameOver=0, playerVisible=0, counters=0.
- States: IDLE, ALIVE, INVULN, EXPLODE, GAME_OVER.
- IDLE/GAME_OVER + startGame=1:
  - Next cycle: state=ALIVE, lives=INIT_LIVES, plrHit=1 for exactly one cycle, cooldown=0.
  - gameOver clears on leaving GAME_OVER.
- ALIVE + hitDetected=1:
  - Next cycle: state=EXPLODE, lives=lives-1, frame counter=EXPLODE_FRAMES.
  - The hit is sampled every clk, not only on startOfFrame.
- EXPLODE:
  - Counter decrements on each startOfFrame.
  - When it reaches 0 with lives>0: state=INVULN, plrHit pulses one cycle, counter=INVULN_FRAMES.
  - When it reaches 0 with lives=0: state=GAME_OVER.
  - playerVisible=1, right/left=0, fire blocked.
- INVULN:
  - hitDetected ignored; movement and fire allowed.
  - playerVisible toggles every BLINK_FRAMES startOfFrame pulses, starting visible.
  - Counter reaches 0 -> ALIVE, playerVisible=1.
- Movement, ALIVE/INVULN only:
  - right = keyRight & ~keyLeft & (playerX < RIGHT_LIMIT).
  - left = keyLeft & ~keyRight & (playerX > LEFT_LIMIT).
  - Both keys pressed -> both 0. Forced 0 in all other states.
- Fire:
  - keyFire is rising-edge detected.
  - An edge in ALIVE/INVULN with cooldown=0 gives fireReq=1 for one cycle and cooldown=FIRE_COOLDOWN.
  - Cooldown decrements per startOfFrame, saturating at 0.
  - Edges while cooldown>0 are dropped, not queued.
- Simultaneous events:
  - hitDetected and a fire edge in the same cycle in ALIVE: hit wins, no fireReq.
  - startGame in ALIVE/INVULN/EXPLODE is ignored.
- lives never underflows; the decrement happens only from ALIVE with lives≥1.
- Reset mid-sequence aborts to IDLE immediately; no plrHit pulse is generated.
- plrHit is driven from a flop and never combinational, because the movement block uses it as an asynchronous reset.

Decomposition:
- Package player_ctrl_pkg holds:
  - the state enum (IDLE, ALIVE, INVULN, EXPLODE, GAME_OVER);
  - LIVES_W=3 and FRAME_CNT_W=8;
  - a shared edge-detect helper function.
- Sub-module frame_countdown: loadable down-counter that decrements on startOfFrame, saturates at 0 and flags zero.
  - Instantiated for the state timer, the blink timer and the fire cooldown.

Test Plan:
- Reset, then startGame pulse -> next cycle ALIVE, lives=3, plrHit high exactly 1 cycle, playerVisible=1.
- ALIVE, hitDetected 1 cycle -> lives=2, exploding=1; after 30 startOfFrame pulses plrHit pulses once, then INVULN blinks at 4-frame halves for 60 frames, then ALIVE.
- hitDetected held continuously during INVULN -> lives unchanged; the first cycle after INVULN ends gives EXPLODE and lives decrements.
- keyFire edges at frames 0, 5, 16 -> fireReq at 0 and 16 only (15-frame cooldown).
- keyRight with playerX=607 -> right=0; keyRight+keyLeft with playerX=300 -> right=left=0.
- Three hits -> GAME_OVER after the third explosion with lives=0, no plrHit; startGame -> ALIVE, lives=3. Reset asserted during EXPLODE -> all outputs at reset values asynchronously.
